// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage vector filter pipeline.
// Produces EX-stage forwarding selects, the load enables and bubble clears
// for the PC and the pipeline buffers, and a saturating stall counter.
// A multi-cycle data-memory access in MEM freezes the whole pipe. A taken
// branch flushes the wrong-path instructions. A load followed by a
// dependent instruction inserts one bubble.
module pipeline_hazard_ctrl #(
    parameter int ADDR_W  = 4,
    parameter int MEM_LAT = 2,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] ra1_d,
    input  logic [ADDR_W-1:0] ra2_d,
    input  logic [ADDR_W-1:0] ra1_e,
    input  logic [ADDR_W-1:0] ra2_e,
    input  logic [ADDR_W-1:0] wa3_e,
    input  logic [ADDR_W-1:0] wa3_m,
    input  logic [ADDR_W-1:0] wa3_w,
    input  logic              regwrite_e,
    input  logic              regwrite_m,
    input  logic              regwrite_w,
    input  logic              memtoreg_e,
    input  logic              memaccess_m,
    input  logic              branch_taken_e,
    output logic [1:0]        fwd_a_e,
    output logic [1:0]        fwd_b_e,
    output logic              en_pc,
    output logic              en_ifid,
    output logic              en_idex,
    output logic              en_exmem,
    output logic              clr_ifid,
    output logic              clr_idex,
    output logic              clr_memwb,
    output logic              mem_busy,
    output logic [CNT_W-1:0]  stall_cycles
);

    typedef enum logic [0:0] {
        ST_RUN     = 1'b0,
        ST_MEMWAIT = 1'b1
    } state_t;

    // A single-cycle memory never needs to freeze the pipe.
    localparam bit MULTI_CYC = (MEM_LAT > 1);
    // The first frozen cycle is spent in RUN, so the wait counter covers the rest.
    localparam logic [3:0] CNT_LOAD = MULTI_CYC ? 4'(MEM_LAT - 2) : 4'd0;

    state_t           state_r;
    state_t           state_nxt_s;
    logic [3:0]       cnt_r;
    logic [3:0]       cnt_nxt_s;
    logic [CNT_W-1:0] stall_cnt_r;
    logic             mem_stall_s;
    logic             ldstall_s;
    logic             stall_any_s;

    // Operand forwarding: the younger MEM result wins over the WB result.
    always_comb begin
        fwd_a_e = 2'b00;
        fwd_b_e = 2'b00;
        if (regwrite_m && (wa3_m == ra1_e)) begin
            fwd_a_e = 2'b10;
        end else if (regwrite_w && (wa3_w == ra1_e)) begin
            fwd_a_e = 2'b01;
        end else begin
            fwd_a_e = 2'b00;
        end
        if (regwrite_m && (wa3_m == ra2_e)) begin
            fwd_b_e = 2'b10;
        end else if (regwrite_w && (wa3_w == ra2_e)) begin
            fwd_b_e = 2'b01;
        end else begin
            fwd_b_e = 2'b00;
        end
    end

    // Hazard detection for the memory freeze and the load-use bubble.
    always_comb begin
        mem_stall_s = ((state_r == ST_RUN) && memaccess_m && MULTI_CYC) ||
                      ((state_r == ST_MEMWAIT) && (cnt_r != 4'd0));
        ldstall_s   = memtoreg_e && regwrite_e &&
                      ((wa3_e == ra1_d) || (wa3_e == ra2_d));
        // Lower-priority hazards are masked by higher ones, but any of them
        // being active means the cycle is lost either way.
        stall_any_s = mem_stall_s || branch_taken_e || ldstall_s;
    end

    // Memory-wait FSM next state; the last wait cycle ignores memaccess_m so
    // the instruction that caused the wait does not retrigger it.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        case (state_r)
            ST_RUN: begin
                if (memaccess_m && MULTI_CYC) begin
                    state_nxt_s = ST_MEMWAIT;
                    cnt_nxt_s   = CNT_LOAD;
                end else begin
                    state_nxt_s = ST_RUN;
                    cnt_nxt_s   = cnt_r;
                end
            end
            ST_MEMWAIT: begin
                if (cnt_r != 4'd0) begin
                    state_nxt_s = ST_MEMWAIT;
                    cnt_nxt_s   = cnt_r - 4'd1;
                end else begin
                    state_nxt_s = ST_RUN;
                    cnt_nxt_s   = 4'd0;
                end
            end
            default: begin
                state_nxt_s = ST_RUN;
                cnt_nxt_s   = 4'd0;
            end
        endcase
    end

    // FSM state and wait counter registers; reset aborts any wait in progress.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_RUN;
            cnt_r   <= 4'd0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Pipeline enables and clears in priority order: reset, freeze, flush, bubble.
    always_comb begin
        en_pc     = 1'b1;
        en_ifid   = 1'b1;
        en_idex   = 1'b1;
        en_exmem  = 1'b1;
        clr_ifid  = 1'b0;
        clr_idex  = 1'b0;
        clr_memwb = 1'b0;
        if (reset) begin
            en_pc     = 1'b0;
            en_ifid   = 1'b0;
            en_idex   = 1'b0;
            en_exmem  = 1'b0;
            clr_ifid  = 1'b1;
            clr_idex  = 1'b1;
            clr_memwb = 1'b1;
        end else if (mem_stall_s) begin
            // Freeze everything upstream; bubble WB so the result is not written twice.
            en_pc     = 1'b0;
            en_ifid   = 1'b0;
            en_idex   = 1'b0;
            en_exmem  = 1'b0;
            clr_memwb = 1'b1;
        end else if (branch_taken_e) begin
            clr_ifid = 1'b1;
            clr_idex = 1'b1;
        end else if (ldstall_s) begin
            en_pc    = 1'b0;
            en_ifid  = 1'b0;
            clr_idex = 1'b1;
        end else begin
            en_pc = 1'b1;
        end
    end

    // Saturating count of cycles lost to any stall, flush or bubble.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_r <= '0;
        end else if (stall_any_s && (stall_cnt_r != {CNT_W{1'b1}})) begin
            stall_cnt_r <= stall_cnt_r + CNT_W'(1);
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign mem_busy     = mem_stall_s;
    assign stall_cycles = stall_cnt_r;

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Hazard and sequencing controller for the 5-stage vector filter pipeline.
- Drives the load enables and synchronous clears of the PC register and the IF/ID, ID/EX, EX/MEM and MEM/WB buffers.
- Generates EX-stage operand forwarding selects.
- Inserts load-use bubbles, flushes wrong-path instructions on taken branches, and freezes the pipe while a multi-cycle data-memory access completes in MEM.

Parameters:
ADDR_W, 4, register address width (16 architectural vector registers)
MEM_LAT, 2, cycles an instruction occupies MEM when it accesses data memory; legal range 1..15
CNT_W, 16, width of the stall performance counter

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
ra1_d  in  ADDR_W  source register 1 of the instruction in ID
ra2_d  in  ADDR_W  source register 2 of the instruction in ID
ra1_e  in  ADDR_W  source register 1 in EX (from the ID/EX buffer)
ra2_e  in  ADDR_W  source register 2 in EX
wa3_e  in  ADDR_W  destination register in EX
wa3_m  in  ADDR_W  destination register in MEM
wa3_w  in  ADDR_W  destination register in WB
regwrite_e  in  1  EX instruction writes the register file
regwrite_m  in  1  MEM instruction writes the register file
regwrite_w  in  1  WB instruction writes the register file
memtoreg_e  in  1  EX instruction is a load
memaccess_m  in  1  MEM instruction is a load or store
branch_taken_e  in  1  branch in EX resolved taken
fwd_a_e  out  2  operand A select: 00 register file, 10 MEM result, 01 WB result
fwd_b_e  out  2  operand B select, same encoding
en_pc  out  1  PC load enable
en_ifid  out  1  IF/ID load enable
en_idex  out  1  ID/EX load enable
en_exmem  out  1  EX/MEM load enable
clr_ifid  out  1  IF/ID captures zeros (bubble) at next edge; dominates en
clr_idex  out  1  ID/EX bubble
clr_memwb  out  1  MEM/WB bubble
mem_busy  out  1  memory-wait freeze active this cycle
stall_cycles  out  CNT_W  saturating count of cycles with any stall or bubble

Behaviour:
- Forwarding is combinational and applies to all 16 registers, including register 0.
  - fwd_a_e = 10 if regwrite_m && wa3_m==ra1_e.
  - Otherwise 01 if regwrite_w && wa3_w==ra1_e.
  - Otherwise 00. MEM has priority over WB.
  - fwd_b_e is identical, using ra2_e.
- ldstall = memtoreg_e && regwrite_e && (wa3_e==ra1_d || wa3_e==ra2_d).
- FSM states and the wait counter (width 4):
  - RUN, MEMWAIT.
  - In RUN with memaccess_m && MEM_LAT>1: go to MEMWAIT and load cnt=MEM_LAT-2.
  - In MEMWAIT with cnt!=0: decrement cnt.
  - In MEMWAIT with cnt==0: go to RUN. memaccess_m is ignored in this cycle, so the same instruction does not retrigger.
- mem_stall = (RUN && memaccess_m && MEM_LAT>1) || (MEMWAIT && cnt!=0).
  - Result: MEM_LAT-1 frozen cycles; the instruction occupies MEM for exactly MEM_LAT cycles.
  - MEM_LAT=1: the FSM never leaves RUN.
- Output priority, highest first:
  1. reset: all en=0, all clr=1.
  2. mem_stall: en_pc=en_ifid=en_idex=en_exmem=0; clr_memwb=1 so WB does not write twice; clr_ifid=clr_idex=0. Branch and ldstall are suppressed, and are re-evaluated once the freeze ends.
  3. branch_taken_e: all en=1; clr_ifid=clr_idex=1; clr_memwb=0. This overrides ldstall.
  4. ldstall: en_pc=en_ifid=0; clr_idex=1; en_exmem=1; the other clears are 0.
  5. Otherwise: all en=1, all clr=0.
- mem_busy = mem_stall.
- stall_cycles increments on every cycle where mem_stall, ldstall (unsuppressed) or a branch flush is active. It saturates at all-ones and does not wrap.
- Reset values, registered on the first edge with reset=1: state=RUN, cnt=0, stall_cycles=0.
  - Reset during MEMWAIT aborts the wait; with reset low, the next cycle is RUN.
- All comparisons are full ADDR_W width; there is no partial decode.

Test Plan:
- Forwarding priority: regwrite_m=1, wa3_m=5; regwrite_w=1, wa3_w=5; ra1_e=5, ra2_e=5 -> fwd_a_e=fwd_b_e=10. Then regwrite_m=0 -> both selects are 01. Then ra1_e=6 -> fwd_a_e=00.
- Load-use: memtoreg_e=1, regwrite_e=1, wa3_e=3, ra2_d=3 -> en_pc=en_ifid=0, clr_idex=1 for one cycle, stall_cycles increments by 1. With ra2_d=4 -> no stall.
- Memory wait, MEM_LAT=4: memaccess_m held high -> mem_busy=1 for exactly 3 cycles with clr_memwb=1, then en_* all return to 1; the FSM passes RUN -> MEMWAIT(2, 1, 0) -> RUN. With MEM_LAT=1 -> no stall.
- Branch during ldstall: branch_taken_e=1 with the ldstall condition true -> en_pc=1, clr_ifid=clr_idex=1. Branch during mem_stall -> flush withheld until the cycle mem_busy drops.
- Reset mid-wait: MEM_LAT=8, reset pulsed in the 3rd wait cycle -> all clr=1, all en=0 during reset; after reset state=RUN and stall_cycles=0.
- Counter saturation: CNT_W=4, hold ldstall for 20 cycles -> stall_cycles stops at 15.
